and_2: RTL and testbench

AND_2 -- requirements
Module: and_2

---
 rtl/and_2_pkg.sv | 23 ++
 rtl/and_2_stage.sv | 42 ++++
 rtl/and_2.sv | 90 +++++++++
 tb/tb_and_2.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/and_2_pkg.sv
// Package: and_2_pkg
// Shared constants for the pipelined bitwise-AND block.
//   DEFAULT_WIDTH        default operand/result width
//   MIN/MAX_PIPE_STAGES  legal range for the PIPE_STAGES parameter
//   MAX_WIDTH            largest supported operand width
//   HIT_COUNT_W          width of the optional hit counter
// paramsLegal() lets the top reject illegal parameter combinations
// at elaboration time.
package and_2_pkg;

  localparam int DEFAULT_WIDTH       = 1;
  localparam int DEFAULT_PIPE_STAGES = 1;
  localparam int MIN_PIPE_STAGES     = 1;
  localparam int MAX_PIPE_STAGES     = 4;
  localparam int MAX_WIDTH           = 64;
  localparam int HIT_COUNT_W         = 16;

  function automatic logic paramsLegal(input int width, input int stages);
    return (width >= 1) && (width <= MAX_WIDTH) &&
           (stages >= MIN_PIPE_STAGES) && (stages <= MAX_PIPE_STAGES);
  endfunction

endpackage

// File: rtl/and_2_stage.sv
// Module: and_2_stage
// One pipeline stage: a valid bit that advances every cycle and a data
// register that loads only when the incoming valid is set.
// Synchronous active-high reset clears both.
//   clk_i    rising-edge clock
//   rst_i    synchronous active-high reset
//   valid_i  incoming valid
//   data_i   incoming data (WIDTH bits)
//   valid_o  registered valid
//   data_o   registered data, held while valid_i is low
module and_2_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Data is not touched on idle cycles, so garbage on the operands while
  // valid is low never reaches the output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/and_2.sv
// Module: and_2
// Pipelined bitwise AND of two operands with a reduction-AND flag.
// Latency is PIPE_STAGES cycles, one operation per cycle, no stall.
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   a, b       operands (WIDTH bits)
//   in_valid   operands valid this cycle
//   result     registered a & b, holds last valid value
//   out_valid  result valid this cycle
//   all_ones   every bit of result is 1 (qualified by out_valid)
//   hit_count  (only with AND_2_STATS_EN) saturating count of cycles
//              with out_valid and all_ones both set
// Optional feature macro: AND_2_STATS_EN
module and_2
  import and_2_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int PIPE_STAGES = DEFAULT_PIPE_STAGES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   in_valid,
  output logic [WIDTH-1:0]       result,
  output logic                   out_valid,
  output logic                   all_ones
`ifdef AND_2_STATS_EN
  ,
  output logic [HIT_COUNT_W-1:0] hit_count
`endif
);

  // Each stage carries the AND result plus its all-ones flag in the MSB,
  // so the flag is registered alongside result in the last stage.
  localparam int STAGE_W = WIDTH + 1;

  logic [WIDTH-1:0]   andValue;
  logic [STAGE_W-1:0] stageData [PIPE_STAGES+1];
  logic [PIPE_STAGES:0] stageValid;

  if (!paramsLegal(WIDTH, PIPE_STAGES)) begin : gBadParams
    $error("and_2: WIDTH or PIPE_STAGES out of range");
  end

  assign andValue      = a & b;
  assign stageData[0]  = {&andValue, andValue};
  assign stageValid[0] = in_valid;

  for (genvar i = 0; i < PIPE_STAGES; i++) begin : gStage
    and_2_stage #(
      .WIDTH (STAGE_W)
    ) uStage (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (stageValid[i]),
      .data_i  (stageData[i]),
      .valid_o (stageValid[i+1]),
      .data_o  (stageData[i+1])
    );
  end

  assign result    = stageData[PIPE_STAGES][WIDTH-1:0];
  assign all_ones  = stageData[PIPE_STAGES][WIDTH];
  assign out_valid = stageValid[PIPE_STAGES];

`ifdef AND_2_STATS_EN
  logic [HIT_COUNT_W-1:0] hitCount_q;
  logic [HIT_COUNT_W-1:0] hitCount_d;

  // Counter sticks at all-ones instead of wrapping.
  always_comb begin
    hitCount_d = hitCount_q;
    if (out_valid && all_ones && (hitCount_q != '1)) begin
      hitCount_d = hitCount_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hitCount_q <= '0;
    end else begin
      hitCount_q <= hitCount_d;
    end
  end

  assign hit_count = hitCount_q;
`endif

endmodule

// File: tb/tb_and_2.sv
// Testbench: tb_and_2
// Directed checks of and_2 in two configurations: WIDTH=1/PIPE_STAGES=1
// and WIDTH=8/PIPE_STAGES=3. Build with AND_2_STATS_EN to also exercise
// the saturating hit counter.
module tb_and_2;

  logic       clk = 1'b0;
  logic       rst;

  logic       a1, b1, v1;
  logic       r1, ov1, ao1;

  logic [7:0] a8, b8;
  logic       v8;
  logic [7:0] r8;
  logic       ov8, ao8;

`ifdef AND_2_STATS_EN
  logic [15:0] hc1, hc8;
`endif

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  and_2 #(.WIDTH(1), .PIPE_STAGES(1)) uDut1 (
    .clk       (clk),
    .rst       (rst),
    .a         (a1),
    .b         (b1),
    .in_valid  (v1),
    .result    (r1),
    .out_valid (ov1),
    .all_ones  (ao1)
`ifdef AND_2_STATS_EN
    ,
    .hit_count (hc1)
`endif
  );

  and_2 #(.WIDTH(8), .PIPE_STAGES(3)) uDut8 (
    .clk       (clk),
    .rst       (rst),
    .a         (a8),
    .b         (b8),
    .in_valid  (v8),
    .result    (r8),
    .out_valid (ov8),
    .all_ones  (ao8)
`ifdef AND_2_STATS_EN
    ,
    .hit_count (hc8)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable to sample.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic v);
    a8 = a;
    b8 = b;
    v8 = v;
    tick();
  endtask

  logic [3:0] expAnd1 = 4'b1000;

  initial begin
    rst = 1'b1;
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; v8 = 1'b0;
    tick();
    tick();

    // Reset state
    checkOutput("rst w1 result", r1, 0);
    checkOutput("rst w1 out_valid", ov1, 0);
    checkOutput("rst w1 all_ones", ao1, 0);
    checkOutput("rst w8 result", r8, 0);
    checkOutput("rst w8 out_valid", ov8, 0);
`ifdef AND_2_STATS_EN
    checkOutput("rst hit_count", hc1, 0);
`endif
    rst = 1'b0;

    // WIDTH=1 truth table, one cycle latency
    for (int i = 0; i < 4; i++) begin
      a1 = i[1];
      b1 = i[0];
      v1 = 1'b1;
      tick();
      checkOutput($sformatf("w1 out_valid ab=%0d%0d", i[1], i[0]), ov1, 1);
      checkOutput($sformatf("w1 result ab=%0d%0d", i[1], i[0]), r1, expAnd1[i]);
      checkOutput($sformatf("w1 all_ones ab=%0d%0d", i[1], i[0]), ao1, expAnd1[i]);
    end
    v1 = 1'b0;
    a1 = 1'b1;
    b1 = 1'b0;
    tick();
    checkOutput("w1 idle out_valid", ov1, 0);
    checkOutput("w1 idle result held", r1, 1);
`ifdef AND_2_STATS_EN
    checkOutput("w1 hit_count one", hc1, 1);
`endif

    // WIDTH=8, three-cycle latency
    applyStimulus(8'hF0, 8'h3C, 1'b1);
    checkOutput("lat cycle1 out_valid", ov8, 0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("lat cycle2 out_valid", ov8, 0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("lat cycle3 out_valid", ov8, 1);
    checkOutput("lat cycle3 result", r8, 8'h30);
    checkOutput("lat cycle3 all_ones", ao8, 0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("lat after out_valid", ov8, 0);
    checkOutput("lat after result held", r8, 8'h30);

    // All ones
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    applyStimulus(8'h00, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("ff out_valid", ov8, 1);
    checkOutput("ff result", r8, 8'hFF);
    checkOutput("ff all_ones", ao8, 1);
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("ff after out_valid", ov8, 0);
    checkOutput("ff after result held", r8, 8'hFF);

    // Back-to-back samples emerge in order
    applyStimulus(8'h0F, 8'hFF, 1'b1);
    applyStimulus(8'hAA, 8'h55, 1'b1);
    applyStimulus(8'hC3, 8'hF3, 1'b1);
    checkOutput("b2b s1 out_valid", ov8, 1);
    checkOutput("b2b s1 result", r8, 8'h0F);
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("b2b s2 out_valid", ov8, 1);
    checkOutput("b2b s2 result", r8, 8'h00);
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("b2b s3 out_valid", ov8, 1);
    checkOutput("b2b s3 result", r8, 8'hC3);
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("b2b end out_valid", ov8, 0);

    // Unknown operands while idle must not disturb the held result
    a8 = 'x;
    b8 = 'x;
    v8 = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("x idle out_valid", ov8, 0);
    checkOutput("x idle result held", r8, 8'hC3);

    // Two samples in flight, then reset at the same edge as a third sample
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    rst = 1'b1;
    a8 = 8'hFF;
    b8 = 8'hFF;
    v8 = 1'b1;
    tick();
    rst = 1'b0;
    v8 = 1'b0;
    checkOutput("flush result", r8, 0);
    checkOutput("flush all_ones", ao8, 0);
    checkOutput("flush out_valid c0", ov8, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput($sformatf("flush out_valid c%0d", i), ov8, 0);
      checkOutput($sformatf("flush result c%0d", i), r8, 0);
    end

    // First sample after reset release
    applyStimulus(8'h5A, 8'hFF, 1'b1);
    checkOutput("post rst c1 out_valid", ov8, 0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("post rst c2 out_valid", ov8, 0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("post rst c3 out_valid", ov8, 1);
    checkOutput("post rst c3 result", r8, 8'h5A);

`ifdef AND_2_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("stats cleared", hc1, 0);
    a1 = 1'b1;
    b1 = 1'b1;
    v1 = 1'b1;
    repeat (70000) tick();
    v1 = 1'b0;
    tick();
    tick();
    checkOutput("stats saturated", hc1, 16'hFFFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("stats after rst", hc1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
